// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshaking,
// round-to-nearest-even, special-value handling and overflow/underflow flags.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opd1,
    input  logic [EXP_W+MAN_W:0]   opd2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   res,
    output logic                   overflow,
    output logic                   underflow,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1: unpack and classify ----------------
    logic                    sa, sb, sgn;
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        fa, fb;
    logic                    nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic signed [EW-1:0]    esum;
    logic                    sp_c;
    logic [W-1:0]            sp_res_c;

    assign sa     = opd1[W-1];
    assign sb     = opd2[W-1];
    assign ea     = opd1[W-2:MAN_W];
    assign eb     = opd2[W-2:MAN_W];
    assign fa     = opd1[MAN_W-1:0];
    assign fb     = opd2[MAN_W-1:0];
    assign sgn    = sa ^ sb;
    assign nan_a  = (&ea) && (|fa);
    assign nan_b  = (&eb) && (|fb);
    assign inf_a  = (&ea) && !(|fa);
    assign inf_b  = (&eb) && !(|fb);
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);
    assign esum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    // Subnormal operands fall into the zero class, so they never raise underflow.
    always_comb begin
        sp_c     = 1'b1;
        sp_res_c = '0;
        if (nan_a || nan_b)
            sp_res_c = QNAN;
        else if ((inf_a && zero_b) || (inf_b && zero_a))
            sp_res_c = QNAN;
        else if (inf_a || inf_b)
            sp_res_c = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (zero_a || zero_b)
            sp_res_c = {sgn, {(W-1){1'b0}}};
        else
            sp_c = 1'b0;
    end

    logic                    v1, sgn1, sp1;
    logic signed [EW-1:0]    exp1;
    logic [MAN_W:0]          ma1, mb1;
    logic [W-1:0]            spres1;
    logic [TAG_W-1:0]        tag1;

    logic                    v2, sgn2, sp2;
    logic signed [EW-1:0]    exp2;
    logic [PW-1:0]           prod2;
    logic [W-1:0]            spres2;
    logic [TAG_W-1:0]        tag2;

    // ---------------- S3: normalise, round, pack ----------------
    logic                    msb, guard, sticky, rnd_up;
    logic [MAN_W-1:0]        kept;
    logic [MAN_W:0]          rsum;
    logic signed [EW-1:0]    efin;
    logic                    ovf_e, unf_e;
    logic [W-1:0]            res_c;
    logic                    ovf_c, unf_c;

    assign msb    = prod2[PW-1];
    assign kept   = msb ? prod2[PW-2:MAN_W+1] : prod2[PW-3:MAN_W];
    assign guard  = msb ? prod2[MAN_W] : prod2[MAN_W-1];
    assign sticky = msb ? (|prod2[MAN_W-1:0]) : (|prod2[MAN_W-2:0]);
    assign rnd_up = guard && (sticky || kept[0]);
    assign rsum   = {1'b0, kept} + {{MAN_W{1'b0}}, rnd_up};
    // A rounding carry leaves the fraction all-zero and bumps the exponent.
    assign efin   = exp2 + EW'(msb) + EW'(rsum[MAN_W]);
    assign unf_e  = efin[EW-1] || (efin == '0);
    assign ovf_e  = !efin[EW-1] && (efin >= EMAX);

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (sp2) begin
            res_c = spres2;
        end else if (ovf_e) begin
            res_c = {sgn2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_c = 1'b1;
        end else if (unf_e) begin
            res_c = {sgn2, {(W-1){1'b0}}};
            unf_c = 1'b1;
        end else begin
            res_c = {sgn2, efin[EXP_W-1:0], rsum[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            sgn1      <= 1'b0;
            sp1       <= 1'b0;
            exp1      <= '0;
            ma1       <= '0;
            mb1       <= '0;
            spres1    <= '0;
            tag1      <= '0;
            v2        <= 1'b0;
            sgn2      <= 1'b0;
            sp2       <= 1'b0;
            exp2      <= '0;
            prod2     <= '0;
            spres2    <= '0;
            tag2      <= '0;
            out_valid <= 1'b0;
            res       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            out_tag   <= '0;
        end else if (en) begin
            v1        <= in_valid;
            sgn1      <= sgn;
            sp1       <= sp_c;
            exp1      <= esum;
            ma1       <= {1'b1, fa};
            mb1       <= {1'b1, fb};
            spres1    <= sp_res_c;
            tag1      <= in_tag;

            v2        <= v1;
            sgn2      <= sgn1;
            sp2       <= sp1;
            exp2      <= exp1;
            prod2     <= PW'(ma1) * PW'(mb1);
            spres2    <= spres1;
            tag2      <= tag1;

            out_valid <= v2;
            res       <= res_c;
            overflow  <= ovf_c;
            underflow <= unf_c;
            out_tag   <= tag2;
        end
    end
endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier, successor to the combinational `fp_mult`. Exponent and mantissa widths are configurable, so one block covers FP16, FP32 and custom formats. It adds a three-stage pipeline with valid/ready handshaking on both sides, round-to-nearest-even, full special-value handling and an underflow flag. It sits between operand sources and result sinks in the FPU datapath and passes a user tag through alongside each operation.

## Interface
- `EXP_W`, 8, exponent field width (≥3).
- `MAN_W`, 23, stored fraction width (≥2); word width `W = 1+EXP_W+MAN_W`.
- `TAG_W`, 4, width of the opaque tag carried with each operation (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block accepts the operand pair this cycle.
- `opd1`, `opd2`  in  W  operands: sign, exponent, fraction.
- `in_tag`  in  TAG_W  tag accompanying the operands.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  sink accepts the result this cycle.
- `res`  out  W  product.
- `overflow`  out  1  finite inputs produced a result rounded to ±inf.
- `underflow`  out  1  nonzero finite result was flushed to ±0.
- `out_tag`  out  TAG_W  tag of the operation on `res`.

## Operation
- Three stages, each with its own valid bit:
  - S1: unpack, detect special cases, compute sign and biased exponent sum.
  - S2: (MAN_W+1)×(MAN_W+1) mantissa multiply.
  - S3: normalise, round, apply overflow/underflow, pack.
- Global advance `en = !out_valid || out_ready`. `in_ready = en`. When `en` is 0, every stage holds.
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Sign: `s = s1 ^ s2`, including on zero, inf and overflow results.
- Exponent: `BIAS = 2^(EXP_W-1)-1`.
  - Compute `e = e1 + e2 - BIAS` in signed EXP_W+2 bits.
  - Add 1 if the product MSB (bit 2·MAN_W+1) is set.
  - Add 1 more if rounding carries out of the mantissa.
- Rounding: round-to-nearest-even using guard bit, round bit and sticky (OR of all lower product bits). A tie rounds up only when the kept LSB is 1.
- Overflow: final `e ≥ 2^EXP_W-1` gives `res = {s, all-ones, 0}` and `overflow=1`.
- Underflow: final `e ≤ 0` with nonzero finite operands gives `res = {s, 0, 0}` and `underflow=1`. Subnormal outputs are not produced.
- Subnormal inputs (exp=0) are treated as ±0, with no underflow flag.
- Special cases, in priority order:
  - Any NaN operand gives canonical qNaN `{0, all-ones, 1, 0…}`.
  - inf×0 gives canonical qNaN.
  - inf×finite or inf×inf gives `{s, all-ones, 0}`.
  - 0×finite gives `{s, 0, 0}`.
  - None of these raise a flag.
- `out_tag` is always `in_tag` of the same operation; ordering is strictly FIFO.

## Timing
- Latency: 3 clock cycles from input transfer to `out_valid` when unstalled.
- Throughput: 1 op/cycle while `out_ready=1`.
- Reset (async assert, release on clock edge):
  - All stage valids are 0 and `out_valid=0`.
  - `res`, `overflow`, `underflow` and `out_tag` are all 0.
  - `in_ready=1` after release.
  - Inputs are ignored while `rst_n=0`.
- Reset mid-operation discards all in-flight operations; no result appears afterwards.
- Stall: while `out_valid && !out_ready`, `res`, the flags and `out_tag` stay stable and `in_ready=0`.
  - At most 3 operations are held.
  - Bubbles are not compressed during a stall.
- Simultaneous output transfer and input transfer in the same cycle is legal; the pipeline advances by one.
- `in_ready` depends combinationally on `out_ready`. No other combinational in→out path exists.
- Payload inputs are don't-care when `in_valid=0`.

## Test plan
- Defaults (FP32), `out_ready=1`: `0x40400000 × 0x40000000` → `res=0x40C00000`, flags 0, `out_valid` exactly 3 cycles after the transfer, tag preserved.
- Rounding tie: `0x3F800001 × 0x3FC00000` → `0x3FC00002`. Also `0x3F800000 × 0x3F800000` → `0x3F800000`.
- Overflow and underflow:
  - `0x7F000000 × 0x40000000` → `0x7F800000`, `overflow=1`.
  - `0x00800000 × 0x3F000000` → `0x00000000`, `underflow=1`.
  - `0xFF000000 × 0x40000000` → `0xFF800000`, `overflow=1`.
- Specials:
  - `0x7F800000 × 0x00000000` → `0x7FC00000`.
  - `0xFFC00001 × 0x3F800000` → `0x7FC00000`.
  - `0x7F800000 × 0xC0000000` → `0xFF800000`.
  - `0x80000000 × 0x40000000` → `0x80000000`.
  - All with flags 0.
- Backpressure: `out_ready=0`, 5 back-to-back inputs with tags 0–4.
  - Exactly 3 are accepted, then `in_ready=0`.
  - Outputs are held stable.
  - After `out_ready=1`, results emerge in tag order 0–4 with no loss or duplicates.
- Reset mid-stream: assert `rst_n=0` with 3 ops in flight → `out_valid=0` and all outputs 0 immediately. After release, only post-reset ops appear. Random stream with `EXP_W=5`, `MAN_W=10` is checked against a reference model.
